id_stage: RTL and testbench

- Decode/operand stage that sits directly upstream of the ALU and feeds its alucontrol, in1, in2, inimm and alusrc inputs.
- Accepts 32-bit RV32I instructions from fetch over a valid/ready handshake.
- Reads the 32x32 register file, generates the immediate and the ALU control code, and holds the result in a single-entry ID/EX output register for the execute stage.
- Writeback from later stages enters through a dedicated write port.

---
 rtl/id_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_id_stage.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// RV32I decode/operand stage: register file, immediate and ALU-control generation,
// and a single-entry ID/EX output register with valid/ready handshakes on both sides.
module id_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alucontrol,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] inimm,
  output logic            alusrc,
  output logic [4:0]      rd,
  output logic            regwrite,
  output logic            memread,
  output logic            memwrite,
  output logic            memtoreg,
  output logic            branch,
  output logic            illegal
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_BR    = 7'b1100011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_e;

  typedef struct packed {
    logic [3:0]      alu;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic [XLEN-1:0] imm;
    logic            alusrc;
    logic [4:0]      rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic            memtoreg;
    logic            branch;
    logic            illegal;
  } idex_t;

  function automatic alu_e alu_of(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_of = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_of = ALU_SLL;
      3'b010:  alu_of = ALU_SLT;
      3'b011:  alu_of = ALU_SLTU;
      3'b100:  alu_of = ALU_XOR;
      3'b101:  alu_of = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [XLEN-1:0] r_regs [NREGS];
  idex_t           r_idex;
  logic            r_valid;
  logic            r_ready_en;

  logic [6:0]      w_op;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic            w_f7_ok;
  logic            w_f7_alt;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_s;
  logic [XLEN-1:0] w_imm_b;
  logic [XLEN-1:0] w_imm_sh;
  logic            w_capture;
  idex_t           w_dec;

  assign w_op     = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7     = instr[31:25];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];
  assign w_f7_ok  = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
  assign w_f7_alt = (w_f7 == 7'b0100000);

  assign w_imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign w_imm_b  = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_imm_sh = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Write-through: a same-cycle writeback is visible to the instruction being captured.
  assign w_rs1_val = (w_rs1 == '0) ? '0 :
                     (wb_en && (wb_rd == w_rs1)) ? wb_data : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == '0) ? '0 :
                     (wb_en && (wb_rd == w_rs2)) ? wb_data : r_regs[w_rs2];

  always_comb begin
    w_dec     = '0;
    w_dec.alu = ALU_ADD;
    w_dec.rd  = instr[11:7];
    w_dec.in1 = w_rs1_val;
    w_dec.in2 = w_rs2_val;
    case (w_op)
      OP_R: begin
        if (!w_f7_ok || (w_f7_alt && (w_f3 != 3'b000) && (w_f3 != 3'b101))) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.regwrite = 1'b1;
          w_dec.alu      = alu_of(w_f3, w_f7_alt);
        end
      end
      OP_I: begin
        // Only shift-immediates carry a funct7; elsewhere instr[31:25] is immediate.
        if ((w_f3 == 3'b001) || (w_f3 == 3'b101)) begin
          if (!w_f7_ok || (w_f7_alt && (w_f3 != 3'b101))) begin
            w_dec.illegal = 1'b1;
          end else begin
            w_dec.regwrite = 1'b1;
            w_dec.alusrc   = 1'b1;
            w_dec.imm      = w_imm_sh;
            w_dec.alu      = alu_of(w_f3, w_f7_alt);
          end
        end else begin
          w_dec.regwrite = 1'b1;
          w_dec.alusrc   = 1'b1;
          w_dec.imm      = w_imm_i;
          w_dec.alu      = alu_of(w_f3, 1'b0);
        end
      end
      OP_LOAD: begin
        w_dec.regwrite = 1'b1;
        w_dec.memread  = 1'b1;
        w_dec.memtoreg = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.imm      = w_imm_i;
      end
      OP_STORE: begin
        w_dec.memwrite = 1'b1;
        w_dec.alusrc   = 1'b1;
        w_dec.imm      = w_imm_s;
        w_dec.rd       = '0;
      end
      OP_BR: begin
        if (w_f3 != 3'b000) begin
          w_dec.illegal = 1'b1;
        end else begin
          // instr[11:7] holds offset bits for a branch, not a destination.
          w_dec.branch = 1'b1;
          w_dec.alu    = ALU_SUB;
          w_dec.imm    = w_imm_b;
          w_dec.rd     = '0;
        end
      end
      default: w_dec.illegal = 1'b1;
    endcase
  end

  assign in_ready  = r_ready_en && (!r_valid || out_ready);
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (wb_en && (wb_rd != '0)) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready_en <= 1'b0;
      r_valid    <= 1'b0;
      r_idex     <= '0;
    end else begin
      r_ready_en <= 1'b1;
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_valid <= 1'b1;
        r_idex  <= w_dec;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_valid;
  assign alucontrol = r_idex.alu;
  assign in1        = r_idex.in1;
  assign in2        = r_idex.in2;
  assign inimm      = r_idex.imm;
  assign alusrc     = r_idex.alusrc;
  assign rd         = r_idex.rd;
  assign regwrite   = r_idex.regwrite;
  assign memread    = r_idex.memread;
  assign memwrite   = r_idex.memwrite;
  assign memtoreg   = r_idex.memtoreg;
  assign branch     = r_idex.branch;
  assign illegal    = r_idex.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed vector table, hand-written handshake/flush/reset
// sequences, and a randomized run against an instruction-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alucontrol;
  logic [31:0] in1, in2, inimm;
  logic        alusrc;
  logic [4:0]  rd;
  logic        regwrite, memread, memwrite, memtoreg, branch, illegal;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .alucontrol(alucontrol),
    .in1(in1), .in2(in2), .inimm(inimm), .alusrc(alusrc), .rd(rd),
    .regwrite(regwrite), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .branch(branch), .illegal(illegal)
  );

  // ctl = {regwrite, memread, memwrite, memtoreg, branch, illegal}
  localparam logic [5:0] RW = 6'b100000;
  localparam logic [5:0] LD = 6'b110100;
  localparam logic [5:0] ST = 6'b001000;
  localparam logic [5:0] BR = 6'b000010;
  localparam logic [5:0] IL = 6'b000001;

  typedef struct packed {
    logic [3:0]  alu;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] imm;
    logic        src;
    logic [4:0]  rd;
    logic [5:0]  ctl;
  } ent_t;

  typedef struct {
    logic [31:0] ins;
    ent_t        exp;
    logic        chk_imm;
  } vec_t;

  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vt[$];

  logic [31:0] m_regs [32];
  logic        m_valid;
  ent_t        m_ent;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic ent_t dut_ent();
    return '{alucontrol, in1, in2, inimm, alusrc, rd,
             {regwrite, memread, memwrite, memtoreg, branch, illegal}};
  endfunction

  function automatic logic [31:0] rt(input logic [6:0] f7, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] f3,
                                     input logic [4:0] d);
    return {f7, rs2, rs1, f3, d, 7'b0110011};
  endfunction

  function automatic logic [31:0] it(input logic [11:0] imm, input logic [4:0] rs1,
                                     input logic [2:0] f3, input logic [4:0] d,
                                     input logic [6:0] op);
    return {imm, rs1, f3, d, op};
  endfunction

  function automatic logic [31:0] st(input logic [11:0] imm, input logic [4:0] rs2,
                                     input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  task automatic add(input logic [31:0] ins, input logic [3:0] alu, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] imm, input logic src,
                     input logic [4:0] d, input logic [5:0] ctl, input logic ci);
    vec_t v;
    v.ins = ins;
    v.exp = '{alu, a, b, imm, src, d, ctl};
    v.chk_imm = ci;
    vt.push_back(v);
  endtask

  // Reference model: RV32I subset rules stated per instruction class.
  function automatic logic [31:0] rdreg(input logic [4:0] idx, input logic wen,
                                        input logic [4:0] wrd, input logic [31:0] wdat);
    if (idx == 5'd0) return 32'd0;
    if (wen && wrd == idx) return wdat;
    return m_regs[idx];
  endfunction

  function automatic ent_t ref_decode(input logic [31:0] ins, input logic wen,
                                      input logic [4:0] wrd, input logic [31:0] wdat);
    ent_t e;
    logic [3:0] tab [8];
    logic [6:0] f7;
    logic [2:0] f3;
    logic       alt, f7ok;
    tab = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    f7   = ins[31:25];
    f3   = ins[14:12];
    alt  = (f7 == 7'h20);
    f7ok = (f7 == 7'h00) || alt;
    e     = '0;
    e.alu = 4'b0010;
    e.rd  = ins[11:7];
    e.in1 = rdreg(ins[19:15], wen, wrd, wdat);
    e.in2 = rdreg(ins[24:20], wen, wrd, wdat);
    case (ins[6:0])
      7'b0110011:
        if (f7ok && (!alt || f3 == 3'd0 || f3 == 3'd5)) begin
          e.ctl = RW;
          e.alu = !alt ? tab[f3] : (f3 == 3'd0 ? 4'b0110 : 4'b0111);
        end else e.ctl = IL;
      7'b0010011:
        if (f3 == 3'd1 || f3 == 3'd5) begin
          if (f7ok && (!alt || f3 == 3'd5)) begin
            e.ctl = RW; e.src = 1'b1; e.imm = 32'(ins[24:20]);
            e.alu = alt ? 4'b0111 : tab[f3];
          end else e.ctl = IL;
        end else begin
          e.ctl = RW; e.src = 1'b1; e.alu = tab[f3];
          e.imm = 32'($signed(ins[31:20]));
        end
      7'b0000011: begin
        e.ctl = LD; e.src = 1'b1; e.imm = 32'($signed(ins[31:20]));
      end
      7'b0100011: begin
        e.ctl = ST; e.src = 1'b1; e.rd = 5'd0;
        e.imm = 32'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011:
        if (f3 == 3'd0) begin
          e.ctl = BR; e.alu = 4'b0110; e.rd = 5'd0;
          e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        end else e.ctl = IL;
      default: e.ctl = IL;
    endcase
    if (e.ctl == IL) e.imm = 32'd0;
    return e;
  endfunction

  task automatic wb_write(input logic [4:0] r, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = r; wb_data = d;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [31:0] ins);
    in_valid = 1'b1; instr = ins;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

    // Directed vector table (x5=5, x6=9, all others 0).
    add(32'h006283B3,                   4'b0010, 5, 9, 0,            0,  7, RW, 1);
    add(rt(7'h20, 6, 5, 3'b000, 8),     4'b0110, 5, 9, 0,            0,  8, RW, 1);
    add(32'hFEC00093,                   4'b0010, 0, 0, 32'hFFFFFFEC, 1,  1, RW, 1);
    add(it(12'h7F0, 5, 3'b111, 2, 7'h13), 4'b0000, 5, 0, 32'h7F0,    1,  2, RW, 1);
    add(it(12'hFFF, 6, 3'b110, 3, 7'h13), 4'b0001, 9, 0, 32'hFFFFFFFF, 1, 3, RW, 1);
    add(rt(7'h00, 6, 5, 3'b100, 4),     4'b0011, 5, 9, 0,            0,  4, RW, 1);
    add(it(12'h003, 5, 3'b001, 9, 7'h13), 4'b0100, 5, 0, 3,          1,  9, RW, 1);
    add(it(12'h41F, 6, 3'b101, 10, 7'h13), 4'b0111, 9, 0, 32'h1F,    1, 10, RW, 1);
    add(rt(7'h00, 6, 5, 3'b101, 11),    4'b0101, 5, 9, 0,            0, 11, RW, 1);
    add(rt(7'h20, 6, 5, 3'b101, 18),    4'b0111, 5, 9, 0,            0, 18, RW, 1);
    add(rt(7'h00, 5, 6, 3'b011, 12),    4'b1001, 9, 5, 0,            0, 12, RW, 1);
    add(it(12'hFFF, 5, 3'b010, 13, 7'h13), 4'b1000, 5, 0, 32'hFFFFFFFF, 1, 13, RW, 1);
    add(it(12'hFFC, 5, 3'b010, 14, 7'h03), 4'b0010, 5, 0, 32'hFFFFFFFC, 1, 14, LD, 1);
    add(st(12'hFF4, 6, 5),              4'b0010, 5, 9, 32'hFFFFFFF4, 1,  0, ST, 1);
    add(32'hFE628CE3,                   4'b0110, 5, 9, 32'hFFFFFFF8, 0,  0, BR, 1);
    add(32'h0000007F,                   4'b0010, 0, 0, 0,            0,  0, IL, 0);
    add({7'h00, 5'd6, 5'd5, 3'b001, 5'd0, 7'b1100011}, 4'b0010, 5, 9, 0, 0, 0, IL, 0);
    add(rt(7'h01, 6, 5, 3'b000, 15),    4'b0010, 5, 9, 0,            0, 15, IL, 0);
    add(rt(7'h20, 6, 5, 3'b111, 16),    4'b0010, 5, 9, 0,            0, 16, IL, 0);
    add(it(12'h403, 5, 3'b001, 17, 7'h13), 4'b0010, 5, 0, 0,         0, 17, IL, 0);

    #12;
    chk("reset.out_valid", out_valid, 0);
    chk("reset.outputs", dut_ent(), '0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("reset.in_ready", in_ready, 1);

    wb_write(5, 32'd5);
    wb_write(6, 32'd9);
    wb_write(0, 32'h1234);

    foreach (vt[i]) begin
      ent_t a, e;
      in_valid = 1'b1; instr = vt[i].ins;
      @(posedge clk); #1;
      a = dut_ent(); e = vt[i].exp;
      if (!vt[i].chk_imm) a.imm = '0;
      chk($sformatf("vec%0d.valid", i), out_valid, 1);
      chk($sformatf("vec%0d.entry", i), a, e);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain.out_valid", out_valid, 0);

    // Backpressure: hold 3 cycles, then capture on the consuming edge.
    issue(32'h006283B3);
    out_ready = 1'b0; in_valid = 1'b1; instr = rt(7'h20, 6, 5, 3'b000, 8);
    #1 chk("hold.in_ready", in_ready, 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d", c), {out_valid, alucontrol, in1, in2, rd},
          {1'b1, 4'b0010, 32'd5, 32'd9, 5'd7});
    end
    out_ready = 1'b1;
    #1 chk("hold.release_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("nobubble", {out_valid, alucontrol, rd}, {1'b1, 4'b0110, 5'd8});

    // Write-through on capture.
    wb_en = 1'b1; wb_rd = 5; wb_data = 32'hDEAD;
    issue(rt(7'h20, 6, 5, 3'b000, 8));
    wb_en = 1'b0;
    chk("wt.in1_alu", {in1, alucontrol, in2}, {32'hDEAD, 4'b0110, 32'd9});

    // Flush beats capture; writeback still lands.
    flush = 1'b1; wb_en = 1'b1; wb_rd = 6; wb_data = 32'h77;
    issue(32'h006283B3);
    flush = 1'b0; wb_en = 1'b0;
    chk("flush.out_valid", out_valid, 0);
    issue(32'h006283B3);
    chk("flush.wb", {out_valid, in1, in2}, {1'b1, 32'hDEAD, 32'h77});

    // Asynchronous reset mid-cycle while holding an entry.
    out_ready = 1'b0;
    issue(32'h006283B3);
    #2 rst_n = 1'b0;
    #1 chk("areset.out_valid", out_valid, 0);
    chk("areset.in1", in1, 0);
    out_ready = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(rt(7'h00, 5, 5, 3'b000, 7));
    chk("areset.x5", {out_valid, in1, in2}, {1'b1, 32'd0, 32'd0});

    // Randomized run against the reference model, from a fresh reset.
    @(negedge clk) rst_n = 1'b0;
    foreach (m_regs[i]) m_regs[i] = '0;
    m_valid = 1'b0; m_ent = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [6:0]  op;
      logic        exp_ready, cap;
      case ($urandom_range(0, 6))
        0: op = 7'b0110011;
        1, 6: op = 7'b0010011;
        2: op = 7'b0000011;
        3: op = 7'b0100011;
        4: op = 7'b1100011;
        default: op = 7'($urandom_range(0, 127));
      endcase
      ins = $urandom;
      ins[6:0] = op;
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) ins[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
      if (op == 7'b1100011 && $urandom_range(0, 3) != 0) ins[14:12] = 3'd0;
      instr = ins;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 11) == 0);
      wb_en     = ($urandom_range(0, 1) == 1);
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      exp_ready = !m_valid || out_ready;
      #1 chk("rnd.in_ready", in_ready, exp_ready);
      cap = in_valid && exp_ready && !flush;
      if (flush) m_valid = 1'b0;
      else if (cap) begin
        m_valid = 1'b1;
        m_ent = ref_decode(ins, wb_en, wb_rd, wb_data);
      end else if (out_ready) m_valid = 1'b0;
      if (wb_en && wb_rd != 0) m_regs[wb_rd] = wb_data;
      @(posedge clk); #1;
      chk("rnd.out_valid", out_valid, m_valid);
      if (m_valid) begin
        ent_t a;
        a = dut_ent();
        if (m_ent.ctl == IL) a.imm = '0;
        chk($sformatf("rnd%0d.entry ins=%h", n, ins), a, m_ent);
      end
    end
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
